// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// 8N1 UART receiver with 16x oversampling, stop-bit check and break handling.
// Define UART_RX_PARITY_EN for 8E1 frames (PARITY state and parity_err strobe).
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | validating the start bit at its mid-point
// DATA   | sampling 8 data bits LSB-first at mid-bit
// PARITY | sampling the parity bit (parity build only)
// STOP   | sampling the stop bit, strobing Rx_done
// BREAK  | line held low after a frame, waiting for it to return high
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       Rx,
  output logic [7:0] Dout,
  output logic       Rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       Rx_busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       s_cnt;
  logic [2:0]       b_cnt;
  logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running oversample tick; the frame logic never restarts it.
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_cnt      <= 4'd0;
      b_cnt      <= 3'd0;
      shift      <= 8'h00;
      Dout       <= 8'h00;
      Rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      Rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      Rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          s_cnt <= 4'd0;
          b_cnt <= 3'd0;
          if (tick && !rx_s) begin
            state   <= START;
            Rx_busy <= 1'b1;
          end
        end
        START: if (tick) begin
          if (s_cnt == 4'd7) begin
            s_cnt <= 4'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              Rx_busy <= 1'b0;
            end
          end else begin
            s_cnt <= s_cnt + 4'd1;
          end
        end
        DATA: if (tick) begin
          s_cnt <= s_cnt + 4'd1;
          if (s_cnt == 4'd15) begin
            shift <= {rx_s, shift[7:1]};
            b_cnt <= b_cnt + 3'd1;
            if (b_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          s_cnt <= s_cnt + 4'd1;
          if (s_cnt == 4'd15) begin
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          s_cnt <= s_cnt + 4'd1;
          if (s_cnt == 4'd15) begin
            Dout      <= shift;
            Rx_done   <= 1'b1;
            frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= ^{shift, par_bit};
`else
            parity_err <= 1'b0;
`endif
            if (rx_s) begin
              state   <= IDLE;
              Rx_busy <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end
        end
        // A held-low line must go high before a new start edge can count.
        BREAK: if (rx_s) begin
          state   <= IDLE;
          Rx_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          Rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Directed bench for uart_receiver at DIV=10 (160 clocks per bit).
module tb_uart_receiver;

  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_NOM = 1680;
  localparam int N_BITS  = 11;
`else
  localparam int LAT_NOM = 1520;
  localparam int N_BITS  = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Rx = 1'b1;
  logic [7:0] Dout;
  logic       Rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       Rx_busy;

  uart_receiver #(
    .CLK_FREQ(1_600_000),
    .BAUD(10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk_100MHz(clk),
    .rst_n(rst_n),
    .Rx(Rx),
    .Dout(Dout),
    .Rx_done(Rx_done),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .Rx_busy(Rx_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc++;

  // Strobe monitor: records every delivered byte and protocol violations.
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         viol_cnt = 0;
  int         last_done_cyc = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;
  logic [7:0] dq[$];
  logic       prev_done = 1'b0;
  logic [7:0] prev_dout = 8'h00;

  always @(negedge clk) begin
    if (Rx_done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      last_dout = Dout;
      last_ferr = frame_err;
      last_perr = parity_err;
      dq.push_back(Dout);
      if (frame_err || parity_err) err_cnt++;
    end
    if (rst_n && prev_done && Rx_done) viol_cnt++;
    if (rst_n && !Rx_done && (frame_err || parity_err)) viol_cnt++;
    if (rst_n && !Rx_done && (Dout !== prev_dout)) viol_cnt++;
    prev_done = Rx_done;
    prev_dout = Dout;
  end

  // Drives one frame starting at the current negedge; optionally pulses
  // rst_n low for 3 clocks in the middle of frame bit rst_at_bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_bit, input int rst_at_bit);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, par_bit, data, 1'b0};
`else
    bits = {par_bit, stop_bit, data, 1'b0};
`endif
    start_cyc = cyc;
    for (int i = 0; i < N_BITS; i++) begin
      Rx = bits[i];
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(negedge clk);
        if (i == rst_at_bit && c == 80) rst_n = 1'b0;
        if (i == rst_at_bit && c == 83) rst_n = 1'b1;
      end
    end
    Rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (Dout !== 8'h00) begin $display("FAIL reset_dout: got %h want %h", Dout, 8'h00); miscompares++; end
    vectors++; if (Rx_done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", Rx_done); miscompares++; end
    vectors++; if (frame_err !== 1'b0) begin $display("FAIL reset_ferr: got %b want 0", frame_err); miscompares++; end
    vectors++; if (parity_err !== 1'b0) begin $display("FAIL reset_perr: got %b want 0", parity_err); miscompares++; end
    vectors++; if (Rx_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", Rx_busy); miscompares++; end
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_single();
    int d0;
    int lat;
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    lat = last_done_cyc - start_cyc;
    vectors++; if (done_cnt - d0 != 1) begin $display("FAIL single_count: got %0d want 1", done_cnt - d0); miscompares++; end
    vectors++; if (last_dout !== 8'hA5) begin $display("FAIL single_dout: got %h want a5", last_dout); miscompares++; end
    vectors++; if (last_ferr !== 1'b0) begin $display("FAIL single_ferr: got %b want 0", last_ferr); miscompares++; end
    vectors++; if (last_perr !== 1'b0) begin $display("FAIL single_perr: got %b want 0", last_perr); miscompares++; end
    vectors++; if (lat < LAT_NOM || lat > LAT_NOM + 15) begin $display("FAIL single_latency: got %0d want %0d..%0d", lat, LAT_NOM, LAT_NOM + 15); miscompares++; end
    vectors++; if (Rx_busy !== 1'b0) begin $display("FAIL single_busy: got %b want 0", Rx_busy); miscompares++; end
  endtask

  task automatic test_back_to_back();
    int d0;
    int e0;
    int q0;
    logic [7:0] g0;
    logic [7:0] g1;
    d0 = done_cnt;
    e0 = err_cnt;
    q0 = dq.size();
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    g0 = (dq.size() > q0) ? dq[q0] : 8'hxx;
    g1 = (dq.size() > q0 + 1) ? dq[q0 + 1] : 8'hxx;
    vectors++; if (done_cnt - d0 != 2) begin $display("FAIL b2b_count: got %0d want 2", done_cnt - d0); miscompares++; end
    vectors++; if (g0 !== 8'h3C) begin $display("FAIL b2b_first: got %h want 3c", g0); miscompares++; end
    vectors++; if (g1 !== 8'hC3) begin $display("FAIL b2b_second: got %h want c3", g1); miscompares++; end
    vectors++; if (err_cnt - e0 != 0) begin $display("FAIL b2b_errors: got %0d want 0", err_cnt - e0); miscompares++; end
  endtask

  task automatic test_glitch();
    int d0;
    d0 = done_cnt;
    Rx = 1'b0;
    repeat (40) @(negedge clk);
    Rx = 1'b1;
    repeat (300) @(negedge clk);
    vectors++; if (done_cnt - d0 != 0) begin $display("FAIL glitch_count: got %0d want 0", done_cnt - d0); miscompares++; end
    vectors++; if (Dout !== 8'hC3) begin $display("FAIL glitch_dout: got %h want c3", Dout); miscompares++; end
    vectors++; if (Rx_busy !== 1'b0) begin $display("FAIL glitch_busy: got %b want 0", Rx_busy); miscompares++; end
  endtask

  task automatic test_break();
    int d0;
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0, -1);
    Rx = 1'b0;
    repeat (5 * BIT_CLKS) @(negedge clk);
    vectors++; if (done_cnt - d0 != 1) begin $display("FAIL break_count: got %0d want 1", done_cnt - d0); miscompares++; end
    vectors++; if (last_dout !== 8'h55) begin $display("FAIL break_dout: got %h want 55", last_dout); miscompares++; end
    vectors++; if (last_ferr !== 1'b1) begin $display("FAIL break_ferr: got %b want 1", last_ferr); miscompares++; end
    vectors++; if (Rx_busy !== 1'b1) begin $display("FAIL break_busy_low: got %b want 1", Rx_busy); miscompares++; end
    Rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    vectors++; if (done_cnt - d0 != 1) begin $display("FAIL break_no_refire: got %0d want 1", done_cnt - d0); miscompares++; end
    vectors++; if (Rx_busy !== 1'b0) begin $display("FAIL break_busy_high: got %b want 0", Rx_busy); miscompares++; end
    send_frame(8'h01, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    vectors++; if (done_cnt - d0 != 2) begin $display("FAIL break_next_count: got %0d want 2", done_cnt - d0); miscompares++; end
    vectors++; if (last_dout !== 8'h01) begin $display("FAIL break_next_dout: got %h want 01", last_dout); miscompares++; end
    vectors++; if (last_ferr !== 1'b0) begin $display("FAIL break_next_ferr: got %b want 0", last_ferr); miscompares++; end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_cnt;
    // Parity bit sent high so the line stays high after the aborted frame.
    send_frame(8'hFF, 1'b1, 1'b1, 5);
    repeat (2 * BIT_CLKS) @(negedge clk);
    vectors++; if (done_cnt - d0 != 0) begin $display("FAIL rstmid_count: got %0d want 0", done_cnt - d0); miscompares++; end
    vectors++; if (Dout !== 8'h00) begin $display("FAIL rstmid_dout: got %h want 00", Dout); miscompares++; end
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    vectors++; if (done_cnt - d0 != 1) begin $display("FAIL rstmid_next_count: got %0d want 1", done_cnt - d0); miscompares++; end
    vectors++; if (last_dout !== 8'h0F) begin $display("FAIL rstmid_next_dout: got %h want 0f", last_dout); miscompares++; end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int d0;
    d0 = done_cnt;
    send_frame(8'h07, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    vectors++; if (last_perr !== 1'b0) begin $display("FAIL parity_good_perr: got %b want 0", last_perr); miscompares++; end
    send_frame(8'h07, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    vectors++; if (done_cnt - d0 != 2) begin $display("FAIL parity_count: got %0d want 2", done_cnt - d0); miscompares++; end
    vectors++; if (last_perr !== 1'b1) begin $display("FAIL parity_bad_perr: got %b want 1", last_perr); miscompares++; end
    vectors++; if (last_dout !== 8'h07) begin $display("FAIL parity_bad_dout: got %h want 07", last_dout); miscompares++; end
    vectors++; if (last_ferr !== 1'b0) begin $display("FAIL parity_bad_ferr: got %b want 0", last_ferr); miscompares++; end
  endtask
`endif

  task automatic test_strobe_protocol();
    vectors++; if (viol_cnt != 0) begin $display("FAIL strobe_protocol: got %0d violations want 0", viol_cnt); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_strobe_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
